acl_spi_reader: RTL
===================

// Module: acl_spi_reader
// PURPOSE
//  SPI master for the on-board ADXL362 accelerometer; the upstream sensor stage of the teeter game.
//  Drives ACL_SCLK/ACL_MOSI/ACL_CSN and samples ACL_MISO.
//  After reset: writes POWER_CTL=measure once, then reads 8-bit signed X/Y/Z every SAMPLE_PERIOD.
//  The game-logic tilt input consumes x_data/y_data/z_data and the data_valid strobe.
// PARAMETERS
//  CLK_DIV        25         CLK cycles per SCLK half-period (min 2); 2 MHz SCLK at 100 MHz CLK
//  SAMPLE_PERIOD  1_000_000  CLK cycles between read-transaction starts (100 Hz)
// PORTS
//  CLK         in   1  system clock, all logic on rising edge
//  RST         in   1  synchronous reset, active-high
//  ACL_MISO    in   1  accelerometer serial data out
//  ACL_SCLK    out  1  SPI clock, mode 0 (idle low)
//  ACL_MOSI    out  1  SPI data to accelerometer
//  ACL_CSN     out  1  chip select, active-low
//  x_data      out  8  signed X tilt (two's complement)
//  y_data      out  8  signed Y tilt
//  z_data      out  8  signed Z tilt
//  data_valid  out  1  one-CLK pulse when x/y/z_data update
// BEHAVIOUR
//  Reset values: ACL_SCLK=0, ACL_MOSI=0, ACL_CSN=1, x/y/z_data=0, data_valid=0, state=CFG_START.
//  Reset mid-transfer: next cycle CSN=1 and SCLK=0; no data_valid; config is redone from scratch.
//  FSM: CFG_START -> CFG_XFER -> GAP -> WAIT -> RD_XFER -> DONE -> WAIT.
//  CFG_START: CSN=0, hold for CLK_DIV cycles (CS setup), then go to CFG_XFER.
//  CFG_XFER: shift 24 bits, MSB first: 0x0A, 0x2D, 0x02.
//  After the last bit: SCLK low for CLK_DIV cycles, then CSN=1, then go to GAP.
//  GAP: CSN=1 for 2*CLK_DIV cycles, then go to WAIT. Sample timer cleared on entry to WAIT.
//  WAIT: leave for RD_XFER when the timer reaches SAMPLE_PERIOD-1.
//   The timer counts from each RD_XFER start.
//   If SAMPLE_PERIOD is shorter than the transaction, the next read starts 2*CLK_DIV cycles after DONE.
//  RD_XFER: same CS setup/hold as config, 40 bits total.
//   MOSI sends 0x0B, 0x08, then 0x00 for the remaining 24 bits.
//   MISO bits 16..39 are captured into the X, Y, Z shift bytes, MSB first.
//  DONE: exactly one cycle. Latch all three bytes into x/y/z_data together; data_valid=1 that cycle.
//   data_valid rises on the cycle after CSN rises.
//  SPI timing (mode 0):
//   - SCLK toggles every CLK_DIV cycles while a transfer is active.
//   - MOSI changes only while SCLK is low: the first bit is set when CSN falls, later bits on each SCLK fall.
//   - MISO is sampled on the CLK cycle where SCLK rises.
//  Bit counter wraps to 0 at transaction end; an incomplete transfer never updates outputs.
//  Outputs hold their last value between data_valid pulses.
// CONFIGURATION
//  ACL_AVG_EN defined: each axis output is a running mean of the last 4 reads.
//   - Sign-extend to 10 bits, sum, arithmetic shift right by 2.
//   - Window history is cleared to 0 by reset, so the first 3 outputs are pre-filled with zeros.
//   - data_valid timing is unchanged; the output is registered in DONE.
//  ACL_AVG_EN undefined: outputs are raw bytes. No history registers are synthesised.
// TESTING  (bench params: CLK_DIV=2, SAMPLE_PERIOD=400; slave model on MISO/MOSI/SCLK/CSN)
//  1. Release RST -> CSN falls the cycle after reset and stays low for exactly 24 SCLK rising edges.
//     Model captures MOSI = 0x0A,0x2D,0x02; CSN then returns high.
//  2. Model returns X=0x12, Y=0x34, Z=0x56 on a read.
//     -> MOSI header 0x0B,0x08; x/y/z=0x12/0x34/0x56; one data_valid pulse the cycle after CSN rises.
//  3. Two consecutive reads: CSN fall-to-fall spacing is exactly 400 CLK cycles.
//     data_valid never asserts outside DONE.
//  4. Assert RST for 1 cycle during bit 20 of a read.
//     -> next cycle CSN=1, SCLK=0, outputs=0, no data_valid; the next transaction is the 24-bit config write.
//  5. Model returns X=0x80 (-128) then 0x7F -> x_data shows 0x80 then 0x7F (raw build).
//  6. ACL_AVG_EN build, X stream 0x10,0x20,0x30,0x40 -> x_data = 0x04,0x0C,0x18,0x28.
//     Then stream 0xF0 x4 -> x_data ends at 0xF0.

Source files
------------

// File: rtl/acl_spi_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : acl_spi_reader                                                |
// | Brief    : ADXL362 SPI master. It configures measure mode once, then     |
// |            reads X/Y/Z periodically. Defining ACL_AVG_EN turns on the    |
// |            4-sample running mean for each axis.                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module acl_spi_reader #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 1_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ACL_MISO,
  output logic       ACL_SCLK,
  output logic       ACL_MOSI,
  output logic       ACL_CSN,
  output logic [7:0] x_data,
  output logic [7:0] y_data,
  output logic [7:0] z_data,
  output logic       data_valid
);

  localparam int              DW           = $clog2(2 * CLK_DIV);
  localparam int              TW           = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [DW-1:0]   DIV_LAST     = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]   GAP_LAST     = DW'(2 * CLK_DIV - 1);
  localparam logic [TW-1:0]   TIMER_LAST   = TW'(SAMPLE_PERIOD - 1);
  localparam logic [39:0]     CFG_FRAME    = 40'h0A2D02_0000;
  localparam logic [39:0]     RD_FRAME     = 40'h0B08_000000;
  localparam logic [5:0]      CFG_LAST_BIT = 6'd23;
  localparam logic [5:0]      RD_LAST_BIT  = 6'd39;
  localparam logic [5:0]      RX_FIRST_BIT = 6'd16;

  typedef enum logic [2:0] {
    CFG_START = 3'd0,
    CFG_XFER  = 3'd1,
    GAP       = 3'd2,
    WAIT      = 3'd3,
    RD_XFER   = 3'd4,
    DONE      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PH_SETUP = 2'd0,
    PH_SHIFT = 2'd1,
    PH_HOLD  = 2'd2,
    PH_END   = 2'd3
  } phase_e;

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [DW-1:0]   div_q, div_d;
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            csn_q, csn_d;
  logic [39:0]     tx_q, tx_d;
  logic [23:0]     rx_q, rx_d;
  logic [7:0]      x_q, x_d, y_q, y_d, z_q, z_d;
  logic            valid_q, valid_d;

  logic            div_tick;
  logic [5:0]      last_bit;
  logic            in_setup, in_shift, in_hold, in_end;

  assign div_tick = (div_q == DIV_LAST);
  assign last_bit = (state_q == RD_XFER) ? RD_LAST_BIT : CFG_LAST_BIT;
  assign in_setup = (state_q == CFG_START) || (state_q == RD_XFER && phase_q == PH_SETUP);
  assign in_shift = (state_q == CFG_XFER || state_q == RD_XFER) && phase_q == PH_SHIFT;
  assign in_hold  = (state_q == CFG_XFER || state_q == RD_XFER) && phase_q == PH_HOLD;
  assign in_end   = (state_q == RD_XFER) && phase_q == PH_END;

`ifdef ACL_AVG_EN
  logic [2:0][7:0] hist_x_q, hist_x_d, hist_y_q, hist_y_d, hist_z_q, hist_z_d;

  function automatic logic [7:0] avg4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    logic [9:0] sum;
    sum = {{2{a[7]}}, a} + {{2{b[7]}}, b} + {{2{c[7]}}, c} + {{2{d[7]}}, d};
    return sum[9:2];
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    div_d     = (div_q == GAP_LAST) ? div_q : div_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    timer_d   = (timer_q == TIMER_LAST) ? timer_q : timer_q + 1'b1;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    csn_d     = csn_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    valid_d   = 1'b0;
`ifdef ACL_AVG_EN
    hist_x_d  = hist_x_q;
    hist_y_d  = hist_y_q;
    hist_z_d  = hist_z_q;
`endif

    // CS setup: drop CSN with the first bit on MOSI, then hold CLK_DIV cycles.
    if (in_setup) begin
      if (csn_q) begin
        csn_d  = 1'b0;
        mosi_d = tx_q[39];
        div_d  = '0;
      end else if (div_tick) begin
        div_d   = '0;
        sclk_d  = 1'b1;
        phase_d = PH_SHIFT;
        if (state_q == CFG_START) begin
          state_d = CFG_XFER;
        end
      end
    end

    if (in_shift && div_tick) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
      if (!sclk_q) begin
        if (state_q == RD_XFER && bit_cnt_q >= RX_FIRST_BIT) begin
          rx_d = {rx_q[22:0], ACL_MISO};
        end
      end else begin
        tx_d   = {tx_q[38:0], 1'b0};
        mosi_d = tx_q[38];
        if (bit_cnt_q == last_bit) begin
          bit_cnt_d = '0;
          phase_d   = PH_HOLD;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end

    if (in_hold && div_tick) begin
      div_d = '0;
      csn_d = 1'b1;
      if (state_q == CFG_XFER) begin
        state_d = GAP;
        phase_d = PH_SETUP;
      end else begin
        phase_d = PH_END;
      end
    end

    // One idle cycle with CSN high before DONE, so data_valid trails the CSN rise.
    if (in_end) begin
      state_d = DONE;
      valid_d = 1'b1;
`ifdef ACL_AVG_EN
      x_d      = avg4(rx_q[23:16], hist_x_q[0], hist_x_q[1], hist_x_q[2]);
      y_d      = avg4(rx_q[15:8],  hist_y_q[0], hist_y_q[1], hist_y_q[2]);
      z_d      = avg4(rx_q[7:0],   hist_z_q[0], hist_z_q[1], hist_z_q[2]);
      hist_x_d = {hist_x_q[1:0], rx_q[23:16]};
      hist_y_d = {hist_y_q[1:0], rx_q[15:8]};
      hist_z_d = {hist_z_q[1:0], rx_q[7:0]};
`else
      x_d = rx_q[23:16];
      y_d = rx_q[15:8];
      z_d = rx_q[7:0];
`endif
    end

    case (state_q)
      GAP: begin
        if (div_q == GAP_LAST) begin
          state_d = WAIT;
          timer_d = '0;
          div_d   = '0;
        end
      end
      // div saturates after DONE and enforces the minimum CSN-high gap.
      WAIT: begin
        if (timer_q == TIMER_LAST && div_q == GAP_LAST) begin
          state_d = RD_XFER;
          phase_d = PH_SETUP;
          timer_d = '0;
          div_d   = '0;
          tx_d    = RD_FRAME;
        end
      end
      DONE: begin
        state_d = WAIT;
        phase_d = PH_SETUP;
        div_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= CFG_START;
      phase_q   <= PH_SETUP;
      div_q     <= '0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      csn_q     <= 1'b1;
      tx_q      <= CFG_FRAME;
      rx_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      csn_q     <= csn_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      valid_q   <= valid_d;
    end
  end

`ifdef ACL_AVG_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      hist_x_q <= '0;
      hist_y_q <= '0;
      hist_z_q <= '0;
    end else begin
      hist_x_q <= hist_x_d;
      hist_y_q <= hist_y_d;
      hist_z_q <= hist_z_d;
    end
  end
`endif

  assign ACL_SCLK   = sclk_q;
  assign ACL_MOSI   = mosi_q;
  assign ACL_CSN    = csn_q;
  assign x_data     = x_q;
  assign y_data     = y_q;
  assign z_data     = z_q;
  assign data_valid = valid_q;

endmodule
`default_nettype wire
